// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic phase shift sequencer.
package pll_ctrl_pkg;

  localparam int CNTSEL_W = 5;

  // PLL counter-select codes driven on cntsel
  localparam logic [CNTSEL_W-1:0] CNT_C0  = 5'b00000;
  localparam logic [CNTSEL_W-1:0] CNT_ALL = 5'b01111;  // all C counters
  localparam logic [CNTSEL_W-1:0] CNT_M   = 5'b10010;

  // Sequencer states: one PLL handshake is EN -> WLO -> WHI -> STEP (-> GAP)
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN    = 3'd1,
    WLO   = 3'd2,
    WHI   = 3'd3,
    STEP  = 3'd4,
    GAP   = 3'd5,
    FIN   = 3'd6,
    ABORT = 3'd7
  } state_e;

endpackage

// File: rtl/pll_dps_ctrl.sv
// Dynamic phase shift sequencer: splits a signed step request into single
// PLL phase-shift handshakes, supervises phase_done with a timeout, watches
// lock, and keeps the signed accumulated position of completed steps.
module pll_dps_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_W    = 9,
  parameter int POS_W     = 12,
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [STEP_W-1:0] req_steps,
  input  logic [CNTSEL_W-1:0]      req_cntsel,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic signed [POS_W-1:0]  pos,
  input  logic                     pll_locked,
  output logic                     phase_en,
  output logic                     updn,
  output logic [CNTSEL_W-1:0]      cntsel,
  input  logic                     phase_done
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ENC_W = $clog2(EN_CYCLES + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ENC_W-1:0]  EN_LAST  = ENC_W'(EN_CYCLES - 1);
  localparam logic [STEP_W-1:0] REM_ONE  = STEP_W'(1);
  localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

  state_e                    state_q, state_d;
  logic                      phase_en_q, phase_en_d;
  logic                      updn_q, updn_d;
  logic [CNTSEL_W-1:0]       cntsel_q, cntsel_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic [STEP_W-1:0]         remaining_q, remaining_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [ENC_W-1:0]          en_cnt_q, en_cnt_d;

  logic                      accept_s;
  logic                      lock_lost_s;
  logic [STEP_W-1:0]         step_mag_s;

  // Ready only from registered state so the core sees a glitch-free handshake.
  assign req_ready   = (state_q == IDLE) && pll_locked;
  assign accept_s    = req_valid && req_ready;
  // Lock loss matters while a handshake may be in flight; FIN and ABORT finish anyway.
  assign lock_lost_s = !pll_locked && (state_q != IDLE) && (state_q != FIN) && (state_q != ABORT);
  // Magnitude as unsigned STEP_W so the most negative request maps to 2**(STEP_W-1).
  assign step_mag_s  = req_steps[STEP_W-1] ? (STEP_W'(0) - $unsigned(req_steps))
                                           : $unsigned(req_steps);

  // Next-state and next-output computation for the step sequencer.
  always_comb begin
    state_d     = state_q;
    updn_d      = updn_q;
    cntsel_d    = cntsel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    pos_d       = pos_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    en_cnt_d    = en_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          updn_d      = ~req_steps[STEP_W-1];
          cntsel_d    = req_cntsel;
          remaining_d = step_mag_s;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          en_cnt_d    = ENC_W'(0);
          state_d     = (step_mag_s == STEP_W'(0)) ? FIN : EN;
        end else begin
          state_d = IDLE;
        end
      end
      EN: begin
        if (en_cnt_q == EN_LAST) begin
          timer_d = TMR_W'(0);
          state_d = WLO;
        end else begin
          en_cnt_d = en_cnt_q + ENC_W'(1);
        end
      end
      WLO: begin
        if (!phase_done) begin
          timer_d = TMR_W'(0);
          state_d = WHI;
        end else if (timer_q == TMR_LAST) begin
          state_d = ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WHI: begin
        if (phase_done) begin
          state_d = STEP;
        end else if (timer_q == TMR_LAST) begin
          state_d = ABORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      STEP: begin
        // The PLL has finished this shift, so it is counted even if lock drops now.
        remaining_d = remaining_q - STEP_W'(1);
        pos_d       = updn_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
        state_d     = (remaining_q == REM_ONE) ? FIN : GAP;
      end
      GAP: begin
        en_cnt_d = ENC_W'(0);
        state_d  = EN;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ABORT: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Lock loss overrides any timeout decided above.
    if (lock_lost_s) begin
      state_d = ABORT;
    end else begin
      state_d = state_d;
    end

    // phase_en is registered and tracks the EN state exactly.
    phase_en_d = (state_d == EN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_en_q  <= 1'b0;
      updn_q      <= 1'b0;
      cntsel_q    <= CNT_C0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pos_q       <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      en_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_en_q  <= phase_en_d;
      updn_q      <= updn_d;
      cntsel_q    <= cntsel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      en_cnt_q    <= en_cnt_d;
    end
  end

  assign phase_en = phase_en_q;
  assign updn     = updn_q;
  assign cntsel   = cntsel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign pos      = pos_q;

endmodule
